// File: rtl/retire_stage.sv
// In-order commit stage: retires up to N completed ROB head entries per cycle, maintains the
// architectural map table, releases stale physical registers, and handles flush/halt.
// Optional build macro RETIRE_STATS_EN adds retired_count and flush_count statistics outputs.
module retire_stage #(
  parameter int N         = 3,
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int PREG_BITS = $clog2(PHYS_REGS),
  parameter int CNT_BITS  = $clog2(N + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CNT_BITS-1:0]            outputs_valid,
  input  logic [N-1:0]                   rob_complete,
  input  logic [N-1:0]                   rob_has_dest,
  input  logic [N*5-1:0]                 rob_arch_reg,
  input  logic [N*PREG_BITS-1:0]         rob_phys_reg,
  input  logic [N*PREG_BITS-1:0]         rob_old_phys_reg,
  input  logic [N-1:0]                   rob_mispredict,
  input  logic [N-1:0]                   rob_halt,
  output logic [CNT_BITS-1:0]            num_retiring,
  output logic [N-1:0]                   free_valid,
  output logic [N*PREG_BITS-1:0]         free_preg,
  output logic                           flush,
  output logic [ARCH_REGS*PREG_BITS-1:0] arch_map,
  output logic                           halted
`ifdef RETIRE_STATS_EN
  ,
  output logic [63:0]                    retired_count,
  output logic [31:0]                    flush_count
`endif
);

  typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

  state_t               state, next_state;
  logic [N-1:0]         retire_mask;
  logic [N-1:0]         write_mask;
  logic                 hit_mispredict;
  logic                 hit_halt;
  logic [PREG_BITS-1:0] map_q [ARCH_REGS];

  // NOTE: every variable gets a default before the scan so no path leaves one unassigned (no latches).
  always_comb begin
    logic stop;
    retire_mask    = '0;
    num_retiring   = '0;
    hit_mispredict = 1'b0;
    hit_halt       = 1'b0;
    stop           = 1'b0;
    if (!reset && state == RUN) begin
      for (int i = 0; i < N; i++) begin
        if (!stop && CNT_BITS'(i) < outputs_valid) begin
          if (rob_complete[i]) begin
            retire_mask[i] = 1'b1;
            num_retiring   = CNT_BITS'(i + 1);
            if (rob_halt[i]) begin
              hit_halt = 1'b1;
              stop     = 1'b1;
            end else if (rob_mispredict[i]) begin
              hit_mispredict = 1'b1;
              stop           = 1'b1;
            end
          end else begin
            stop = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      write_mask[i] = retire_mask[i] && rob_has_dest[i] && (rob_arch_reg[i*5 +: 5] != 5'd0);
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (hit_halt)            next_state = HALTED;
        else if (hit_mispredict) next_state = FLUSH;
      end
      FLUSH:   next_state = RUN;
      HALTED:  next_state = HALTED;
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  assign flush  = (state == FLUSH);
  assign halted = (state == HALTED);

  // NOTE: the map table is a reset register file, not a RAM: recovery needs the identity mapping after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < ARCH_REGS; r++) map_q[r] <= PREG_BITS'(r);
      free_valid <= '0;
      free_preg  <= '0;
    end else begin
      free_valid <= write_mask;
      for (int i = 0; i < N; i++) begin
        free_preg[i*PREG_BITS +: PREG_BITS] <=
          write_mask[i] ? rob_old_phys_reg[i*PREG_BITS +: PREG_BITS] : '0;
        // NOTE: non-blocking writes in slot order, so the youngest slot's write to a register lands last and wins.
        if (write_mask[i])
          map_q[rob_arch_reg[i*5 +: 5]] <= rob_phys_reg[i*PREG_BITS +: PREG_BITS];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < ARCH_REGS; r++) arch_map[r*PREG_BITS +: PREG_BITS] = map_q[r];
  end

`ifdef RETIRE_STATS_EN
  logic [64:0] retired_sum;
  assign retired_sum = {1'b0, retired_count} + 65'(num_retiring);

  always_ff @(posedge clock) begin
    if (reset) begin
      retired_count <= '0;
      flush_count   <= '0;
    end else begin
      retired_count <= retired_sum[64] ? '1 : retired_sum[63:0];
      if (state == RUN && next_state == FLUSH) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_retire_stage.sv
// Directed self-checking bench for retire_stage (N=3, 32 arch regs, 64 phys regs).
module tb_retire_stage;

  localparam int N  = 3;
  localparam int PB = 6;
  localparam int CB = 2;

  logic            clock;
  logic            reset;
  logic [CB-1:0]   outputs_valid;
  logic [N-1:0]    rob_complete, rob_has_dest, rob_mispredict, rob_halt;
  logic [N*5-1:0]  rob_arch_reg;
  logic [N*PB-1:0] rob_phys_reg, rob_old_phys_reg;
  logic [CB-1:0]   num_retiring;
  logic [N-1:0]    free_valid;
  logic [N*PB-1:0] free_preg;
  logic            flush, halted;
  logic [32*PB-1:0] arch_map;
`ifdef RETIRE_STATS_EN
  logic [63:0]     retired_count;
  logic [31:0]     flush_count;
`endif

  int compared   = 0;
  int mismatched = 0;

  retire_stage dut (
    .clock            (clock),
    .reset            (reset),
    .outputs_valid    (outputs_valid),
    .rob_complete     (rob_complete),
    .rob_has_dest     (rob_has_dest),
    .rob_arch_reg     (rob_arch_reg),
    .rob_phys_reg     (rob_phys_reg),
    .rob_old_phys_reg (rob_old_phys_reg),
    .rob_mispredict   (rob_mispredict),
    .rob_halt         (rob_halt),
    .num_retiring     (num_retiring),
    .free_valid       (free_valid),
    .free_preg        (free_preg),
    .flush            (flush),
    .arch_map         (arch_map),
    .halted           (halted)
`ifdef RETIRE_STATS_EN
    ,
    .retired_count    (retired_count),
    .flush_count      (flush_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PB-1:0] amap(input int r);
    return arch_map[r*PB +: PB];
  endfunction

  task automatic clear_slots();
    outputs_valid    = '0;
    rob_complete     = '0;
    rob_has_dest     = '0;
    rob_arch_reg     = '0;
    rob_phys_reg     = '0;
    rob_old_phys_reg = '0;
    rob_mispredict   = '0;
    rob_halt         = '0;
  endtask

  task automatic set_slot(input int i, input logic c, input logic hd, input logic [4:0] a,
                          input logic [PB-1:0] p, input logic [PB-1:0] o,
                          input logic m, input logic h);
    rob_complete[i]               = c;
    rob_has_dest[i]               = hd;
    rob_arch_reg[i*5 +: 5]        = a;
    rob_phys_reg[i*PB +: PB]      = p;
    rob_old_phys_reg[i*PB +: PB]  = o;
    rob_mispredict[i]             = m;
    rob_halt[i]                   = h;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    clear_slots();
    @(negedge clock);
    // Reset held with complete entries presented: nothing may retire.
    outputs_valid = 2'd3;
    for (int i = 0; i < N; i++) set_slot(i, 1'b1, 1'b1, 5'(i + 1), 6'(50 + i), 6'(i + 1), 1'b0, 1'b0);
    #1 check("num_in_reset", num_retiring, 2'd0);
    tick();
    clear_slots();
    reset = 1'b0;
    check("rst_halted", halted, 1'b0);
    check("rst_flush", flush, 1'b0);
    check("rst_free_valid", free_valid, 3'b000);
    check("rst_map5", amap(5), 6'd5);
    check("rst_map31", amap(31), 6'd31);

    // Full-width retire of r1/r2/r3 -> p33/p34/p35.
    outputs_valid = 2'd3;
    set_slot(0, 1'b1, 1'b1, 5'd1, 6'd33, 6'd1, 1'b0, 1'b0);
    set_slot(1, 1'b1, 1'b1, 5'd2, 6'd34, 6'd2, 1'b0, 1'b0);
    set_slot(2, 1'b1, 1'b1, 5'd3, 6'd35, 6'd3, 1'b0, 1'b0);
    #1 check("full_num", num_retiring, 2'd3);
    tick();
    outputs_valid = 2'd0;
    check("full_free_valid", free_valid, 3'b111);
    check("full_free_preg", free_preg, {6'd3, 6'd2, 6'd1});
    check("full_map1", amap(1), 6'd33);
    check("full_map2", amap(2), 6'd34);
    check("full_map3", amap(3), 6'd35);
    #1 check("idle_num", num_retiring, 2'd0);
    tick();
    check("idle_free_valid", free_valid, 3'b000);
    check("idle_map3", amap(3), 6'd35);

    // Partial completion 101: only slot 0 retires.
    clear_slots();
    outputs_valid = 2'd3;
    set_slot(0, 1'b1, 1'b1, 5'd4, 6'd36, 6'd4, 1'b0, 1'b0);
    set_slot(1, 1'b0, 1'b1, 5'd6, 6'd37, 6'd6, 1'b0, 1'b0);
    set_slot(2, 1'b1, 1'b1, 5'd7, 6'd38, 6'd7, 1'b0, 1'b0);
    #1 check("gap_num", num_retiring, 2'd1);
    tick();
    outputs_valid = 2'd0;
    check("gap_free_valid", free_valid, 3'b001);
    check("gap_free_preg0", free_preg[0 +: PB], 6'd4);
    check("gap_map4", amap(4), 6'd36);
    check("gap_map6", amap(6), 6'd6);
    check("gap_map7", amap(7), 6'd7);

    // Combinational boundaries without clocking.
    outputs_valid = 2'd3;
    rob_complete  = 3'b110;
    #1 check("head_incomplete_num", num_retiring, 2'd0);
    outputs_valid = 2'd2;
    rob_complete  = 3'b111;
    #1 check("ov2_num", num_retiring, 2'd2);
    outputs_valid = 2'd0;
    #1 check("ov0_num", num_retiring, 2'd0);

    // Mispredict in slot 1.
    clear_slots();
    outputs_valid = 2'd3;
    set_slot(0, 1'b1, 1'b1, 5'd8,  6'd45, 6'd8,  1'b0, 1'b0);
    set_slot(1, 1'b1, 1'b1, 5'd9,  6'd46, 6'd9,  1'b1, 1'b0);
    set_slot(2, 1'b1, 1'b1, 5'd10, 6'd47, 6'd10, 1'b0, 1'b0);
    #1 check("mis_num", num_retiring, 2'd2);
    tick();
    check("mis_flush", flush, 1'b1);
    check("mis_free_valid", free_valid, 3'b011);
    check("mis_map9", amap(9), 6'd46);
    check("mis_map10", amap(10), 6'd10);
    clear_slots();
    outputs_valid = 2'd3;
    set_slot(0, 1'b1, 1'b1, 5'd11, 6'd48, 6'd11, 1'b0, 1'b0);
    set_slot(1, 1'b1, 1'b1, 5'd12, 6'd49, 6'd12, 1'b0, 1'b0);
    set_slot(2, 1'b1, 1'b1, 5'd13, 6'd50, 6'd13, 1'b0, 1'b0);
    #1 check("flush_num", num_retiring, 2'd0);
    tick();
    check("post_flush_flush", flush, 1'b0);
    check("post_flush_free_valid", free_valid, 3'b000);
    check("post_flush_map11", amap(11), 6'd11);
    #1 check("resume_num", num_retiring, 2'd3);
    tick();
    outputs_valid = 2'd0;
    check("resume_map11", amap(11), 6'd48);
    check("resume_map13", amap(13), 6'd50);

    // Same arch reg from slots 0 and 2; slot 1 targets r0.
    clear_slots();
    outputs_valid = 2'd3;
    set_slot(0, 1'b1, 1'b1, 5'd5, 6'd40, 6'd5,  1'b0, 1'b0);
    set_slot(1, 1'b1, 1'b1, 5'd0, 6'd44, 6'd20, 1'b0, 1'b0);
    set_slot(2, 1'b1, 1'b1, 5'd5, 6'd41, 6'd51, 1'b0, 1'b0);
    #1 check("waw_num", num_retiring, 2'd3);
    tick();
    outputs_valid = 2'd0;
    check("waw_map5", amap(5), 6'd41);
    check("waw_map0", amap(0), 6'd0);
    check("waw_free_valid", free_valid, 3'b101);
    check("waw_free_preg0", free_preg[0 +: PB], 6'd5);
    check("waw_free_preg2", free_preg[2*PB +: PB], 6'd51);

    // Halt and mispredict together in slot 0: halt wins, scan stops.
    clear_slots();
    outputs_valid = 2'd3;
    set_slot(0, 1'b1, 1'b1, 5'd14, 6'd52, 6'd14, 1'b1, 1'b1);
    set_slot(1, 1'b1, 1'b1, 5'd1,  6'd60, 6'd33, 1'b0, 1'b0);
    set_slot(2, 1'b1, 1'b1, 5'd1,  6'd61, 6'd60, 1'b0, 1'b0);
    #1 check("halt_num", num_retiring, 2'd1);
    tick();
    check("halt_halted", halted, 1'b1);
    check("halt_flush", flush, 1'b0);
    check("halt_map14", amap(14), 6'd52);
    rob_halt       = '0;
    rob_mispredict = '0;
    for (int k = 0; k < 10; k++) begin
      #1 check($sformatf("halted_num_%0d", k), num_retiring, 2'd0);
      tick();
    end
    check("halted_still", halted, 1'b1);
    check("halted_free_valid", free_valid, 3'b000);
    check("halted_map1", amap(1), 6'd33);

    // Reset out of HALTED.
    reset = 1'b1;
    #1 check("halt_reset_num", num_retiring, 2'd0);
    tick();
    reset = 1'b0;
    clear_slots();
    check("reset_halted", halted, 1'b0);
    check("reset_map1", amap(1), 6'd1);
    check("reset_map5", amap(5), 6'd5);
    check("reset_map14", amap(14), 6'd14);
    check("reset_free_preg", free_preg, '0);

`ifdef RETIRE_STATS_EN
    check("stats_rst_retired", retired_count, 64'd0);
    check("stats_rst_flush", flush_count, 32'd0);
    rob_complete  = 3'b111;
    outputs_valid = 2'd3;
    tick();
    outputs_valid = 2'd2;
    tick();
    outputs_valid = 2'd0;
    tick();
    check("stats_retired", retired_count, 64'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/retire_stage.md
# retire_stage

In-order commit stage that consumes the oldest N ROB entries each cycle and tells the ROB how many to clear. It maintains the architectural map table, returns stale physical registers to the free list, raises a one-cycle flush on a retired mispredicted branch, and enters a terminal halted state on a retired halt. It sits directly downstream of the ROB and upstream of the free list and the map-table recovery logic.

## Interface
- N, 3, retire width; matches ROB output width
- ARCH_REGS, 32, architectural register count
- PHYS_REGS, 64, physical register count; PREG_BITS = $clog2(PHYS_REGS), CNT_BITS = $clog2(N+1)
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- outputs_valid  in  CNT_BITS  number of valid ROB head entries presented; slot 0 is oldest
- rob_complete  in  N  per-slot completed flag
- rob_has_dest  in  N  slot writes a destination register
- rob_arch_reg  in  N×5  destination architectural register
- rob_phys_reg  in  N×PREG_BITS  new physical register
- rob_old_phys_reg  in  N×PREG_BITS  previous mapping, freed on retire
- rob_mispredict  in  N  slot is a resolved mispredicted branch
- rob_halt  in  N  slot is a halt instruction
- num_retiring  out  CNT_BITS  entries ROB clears this cycle (combinational)
- free_valid  out  N  registered free-list release strobes
- free_preg  out  N×PREG_BITS  registered released physical registers
- flush  out  1  registered one-cycle pipeline flush pulse
- arch_map  out  ARCH_REGS×PREG_BITS  architectural map table, for flush recovery
- halted  out  1  terminal halted flag

## Operation
- States: RUN, FLUSH, HALTED.
- RUN: scan slots 0..outputs_valid-1 in order; slot i retires iff all slots 0..i retire and rob_complete[i]=1. Scan stops after the first non-complete slot, after the first retiring slot with rob_mispredict, or after the first retiring slot with rob_halt.
- num_retiring = count of retiring slots; never exceeds outputs_valid.
- Retiring slot with rob_has_dest and rob_arch_reg≠0: arch_map[arch_reg] <= phys_reg; next cycle free_valid[i]=1, free_preg[i]=old_phys_reg. Otherwise free_valid[i]=0.
- Two retiring slots writing the same arch_reg in one cycle: younger (higher index) mapping wins; both old_phys_regs are freed.
- Mispredict retired: next state FLUSH. Halt retired: next state HALTED. Both in one slot: halt wins.
- FLUSH: flush=1 for exactly this cycle; num_retiring=0; return to RUN.
- HALTED: num_retiring=0, free_valid=0, arch_map frozen; leaves only on reset.
- arch_map[0] is always 0 and is never written.

## Timing
- num_retiring: zero-latency combinational from inputs and current state.
- arch_map, free_valid/free_preg, flush, halted: update on the clock edge after the retiring cycle.
- Reset (any cycle, including FLUSH or HALTED): state RUN, arch_map[r]=r for all r, free_valid=0, free_preg=0, flush=0, halted=0. num_retiring=0 while reset is high.
- outputs_valid=0: num_retiring=0, no state change.
- Incomplete slot 0: num_retiring=0 regardless of later slots.

## Configuration
- RETIRE_STATS_EN defined: adds output retired_count (64 bits). It resets to 0, increments by num_retiring each cycle, and saturates at all-ones. It also adds output flush_count (32 bits), which increments on each FLUSH entry.
- RETIRE_STATS_EN undefined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- N=3, outputs_valid=3, complete=111, dests r1/r2/r3 -> p33/p34/p35, old p1/p2/p3 -> num_retiring=3; next cycle free_valid=111 with free_preg p1,p2,p3; arch_map[1..3]=33,34,35.
- complete=101, outputs_valid=3 -> num_retiring=1; only slot 0 is freed.
- Slot 1 mispredict with all complete -> num_retiring=2; next cycle flush=1 and num_retiring=0; the following cycle flush=0 and retirement resumes.
- Slot 0 halt -> num_retiring=1; then halted=1 and num_retiring stays 0 with complete inputs for 10 cycles; reset then gives halted=0 and identity arch_map.
- Slots 0 and 2 both write r5 (p40, p41) -> arch_map[5]=41, both old pregs freed; a write to r0 is ignored with free_valid=0 for that slot.
- RETIRE_STATS_EN: retire 3, 2 and 0 across three cycles -> retired_count=5.
